// File: rtl/datapath_sequencer.sv
// datapath_sequencer: instruction register plus Moore FSM that steps a simple
// register-file/ALU datapath through MOV imm, MOV reg, ADD, CMP, AND and MVN.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN -- when defined, an illegal opcode
// parks the FSM in HALT with a sticky illegal flag until reset; when undefined,
// illegal opcodes fall straight back to WAIT and illegal is tied low.
module datapath_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        s,
   input  logic [15:0] in,
   output logic        w,
   output logic [15:0] datapath_in,
   output logic        vsel,
   output logic [2:0]  writenum,
   output logic [2:0]  readnum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_WAIT   = 4'd0,
      S_DECODE = 4'd1,
      S_WIMM   = 4'd2,
      S_GETA   = 4'd3,
      S_GETB   = 4'd4,
      S_ALU    = 4'd5,
      S_WREG   = 4'd6,
      S_CMP    = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] ir_reg, ir_next;

   // Instruction fields
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn, rd, rm;
   logic [1:0] sh;

   assign opcode = ir_reg[15:13];
   assign op     = ir_reg[12:11];
   assign rn     = ir_reg[10:8];
   assign rd     = ir_reg[7:5];
   assign sh     = ir_reg[4:3];
   assign rm     = ir_reg[2:0];

   // Instruction classes; every op of the 101 group is a defined ALU instruction
   logic is_mov_imm, is_mov_reg, is_alu_grp, is_cmp, is_mvn, is_legal;

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu_grp = (opcode == 3'b101);
   assign is_cmp     = is_alu_grp && (op == 2'b01);
   assign is_mvn     = is_alu_grp && (op == 2'b11);
   assign is_legal   = is_mov_imm || is_mov_reg || is_alu_grp;

   // Sign-extend imm8: low byte straight through, upper byte replicates bit 7
   genvar gi;
   assign datapath_in[7:0] = ir_reg[7:0];
   generate
      for (gi = 8; gi < 16; gi++) begin : g_sext
         assign datapath_in[gi] = ir_reg[7];
      end
   endgenerate

   // IR captures only while idle so a running instruction cannot be disturbed
   always_comb begin
      ir_next = ir_reg;
      if (state_reg == S_WAIT && load) begin
         ir_next = in;
      end
   end

   // State and instruction register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_WAIT;
         ir_reg    <= 16'h0000;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
      end
   end

`ifdef SEQ_ILLEGAL_TRAP_EN
   logic illegal_reg, illegal_next;

   // Sticky flag set when an illegal opcode is decoded; only reset clears it
   always_comb begin
      illegal_next = illegal_reg;
      if (state_reg == S_DECODE && !is_legal) begin
         illegal_next = 1'b1;
      end
   end

   // Illegal flag register
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_reg <= 1'b0;
      end else begin
         illegal_reg <= illegal_next;
      end
   end

   assign illegal = illegal_reg;
`else
   assign illegal = 1'b0;
`endif

   // Next-state logic and Moore control outputs
   always_comb begin
      state_next = state_reg;
      w          = 1'b0;
      vsel       = 1'b0;
      writenum   = 3'd0;
      readnum    = 3'd0;
      write      = 1'b0;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      shift      = 2'b00;
      ALUop      = 2'b00;

      case (state_reg)
         S_WAIT: begin
            w = 1'b1;
            if (s) begin
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_mov_imm) begin
               state_next = S_WIMM;
            end else if (is_mov_reg || is_mvn) begin
               state_next = S_GETB;
            end else if (is_alu_grp) begin
               state_next = S_GETA;
            end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
               state_next = S_HALT;
`else
               state_next = S_WAIT;
`endif
            end
         end
         S_WIMM: begin
            vsel       = 1'b1;
            write      = 1'b1;
            writenum   = rn;
            state_next = S_WAIT;
         end
         S_GETA: begin
            readnum    = rn;
            loada      = 1'b1;
            state_next = S_GETB;
         end
         S_GETB: begin
            readnum    = rm;
            loadb      = 1'b1;
            state_next = is_cmp ? S_CMP : S_ALU;
         end
         S_ALU: begin
            // Single-operand instructions zero the A input so B passes through
            shift      = sh;
            ALUop      = op;
            loadc      = 1'b1;
            asel       = is_mov_reg || is_mvn;
            state_next = S_WREG;
         end
         S_WREG: begin
            write      = 1'b1;
            writenum   = rd;
            state_next = S_WAIT;
         end
         S_CMP: begin
            shift      = sh;
            ALUop      = 2'b01;
            loads      = 1'b1;
            state_next = S_WAIT;
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_WAIT;
         end
      endcase
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed cases plus randomized
// instruction streams compared cycle by cycle against a per-instruction
// expected control schedule derived from the instruction's meaning.
`timescale 1ns/1ps
module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        reset, load, s;
   logic [15:0] in;
   logic        w, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal;
   logic [15:0] datapath_in;
   logic [2:0]  writenum, readnum;
   logic [1:0]  shift, alu_op;

   datapath_sequencer dut (
      .clk(clk), .reset(reset), .load(load), .s(s), .in(in),
      .w(w), .datapath_in(datapath_in), .vsel(vsel),
      .writenum(writenum), .readnum(readnum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .shift(shift), .ALUop(alu_op),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        w;
      logic [15:0] dp;
      logic        vsel;
      logic [2:0]  writenum;
      logic [2:0]  readnum;
      logic        write, loada, loadb, loadc, loads, asel, bsel;
      logic [1:0]  shift;
      logic [1:0]  aluop;
      logic        illegal;
   } ctl_t;

   int tests_run    = 0;
   int tests_failed = 0;

   ctl_t  exp_q[$];
   string tag_q[$];

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic ctl_t observe();
      return {w, datapath_in, vsel, writenum, readnum, write, loada, loadb,
              loadc, loads, asel, bsel, shift, alu_op, illegal};
   endfunction

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   function automatic bit is_legal(input logic [15:0] ir);
      return (ir[15:13] == 3'b101) ||
             (ir[15:13] == 3'b110 && (ir[12:11] == 2'b10 || ir[12:11] == 2'b00));
   endfunction

   // Reference model: what the datapath must see each cycle after s is taken
   task automatic build_expected(input logic [15:0] ir);
      ctl_t c, base;
      logic [2:0] opc = ir[15:13];
      logic [1:0] op  = ir[12:11];
      bit mov_imm = (opc == 3'b110) && (op == 2'b10);
      bit mov_reg = (opc == 3'b110) && (op == 2'b00);
      bit alu     = (opc == 3'b101);
      exp_q.delete();
      tag_q.delete();
      base    = '0;
      base.dp = sext8(ir[7:0]);
      exp_q.push_back(base); tag_q.push_back("decode");
      if (mov_imm) begin
         c = base; c.vsel = 1; c.write = 1; c.writenum = ir[10:8];
         exp_q.push_back(c); tag_q.push_back("wimm");
      end else if (alu || mov_reg) begin
         if (alu && op != 2'b11) begin
            c = base; c.readnum = ir[10:8]; c.loada = 1;
            exp_q.push_back(c); tag_q.push_back("geta");
         end
         c = base; c.readnum = ir[2:0]; c.loadb = 1;
         exp_q.push_back(c); tag_q.push_back("getb");
         if (alu && op == 2'b01) begin
            c = base; c.shift = ir[4:3]; c.aluop = 2'b01; c.loads = 1;
            exp_q.push_back(c); tag_q.push_back("cmp");
         end else begin
            c = base; c.shift = ir[4:3]; c.aluop = op; c.loadc = 1;
            c.asel = mov_reg || (op == 2'b11);
            exp_q.push_back(c); tag_q.push_back("alu");
            c = base; c.write = 1; c.writenum = ir[7:5];
            exp_q.push_back(c); tag_q.push_back("wreg");
         end
      end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
         for (int k = 0; k < 4; k++) begin
            c = base; c.illegal = 1;
            exp_q.push_back(c); tag_q.push_back("halt");
         end
         return;
`endif
      end
      c = base; c.w = 1;
      exp_q.push_back(c); tag_q.push_back("done");
   endtask

   task automatic do_reset();
      ctl_t idle;
      @(negedge clk);
      reset = 1; s = 0; load = 0;
      @(negedge clk);
      reset = 0;
      idle = '0; idle.w = 1;
      check("reset", observe(), idle);
   endtask

   // Run one instruction; noise drives random s/load/in while busy,
   // split loads IR a cycle before s, abort_at fires reset after that cycle.
   task automatic run_instr(input logic [15:0] instr, input bit noise,
                            input bit split, input int abort_at);
      ctl_t c;
      ctl_t idle;
      build_expected(instr);
      @(negedge clk);
      in = instr; load = 1;
      if (split) begin
         s = 0;
         @(negedge clk);
         load = 0;
         c = '0; c.w = 1; c.dp = sext8(instr[7:0]);
         check($sformatf("wait_load %h", instr), observe(), c);
         in = 16'($urandom);
      end
      s = 1;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         check($sformatf("%s %h c%0d", tag_q[i], instr, i), observe(), exp_q[i]);
         if (i == abort_at) begin
            s = 0; load = 0; reset = 1;
            @(negedge clk);
            reset = 0;
            idle = '0; idle.w = 1;
            check($sformatf("abort %h", instr), observe(), idle);
            return;
         end
         if (noise && i < exp_q.size() - 1) begin
            s = 1'($urandom); load = 1'($urandom); in = 16'($urandom);
         end else begin
            s = 0; load = 0;
         end
      end
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r = 16'($urandom);
      case ($urandom_range(0, 5))
         0:       r[15:11] = 5'b11010;
         1:       r[15:11] = 5'b11000;
         2, 3:    r[15:13] = 3'b101;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      logic [15:0] ins;
      reset = 1; load = 0; s = 0; in = 16'h0000;
      repeat (2) @(negedge clk);
      do_reset();

      run_instr(16'hD32A, 0, 0, -1);     // MOV R3,#42
      run_instr(16'hD4F3, 0, 1, -1);     // MOV R4,#-13
      run_instr(16'hA3B5, 0, 0, -1);     // ADD R5,R3,R5
      run_instr(16'hAB0D, 1, 0, -1);     // CMP R3,R5 with s/load noise
      run_instr(16'hA3B5, 0, 0, 3);      // reset during ALU
      run_instr(16'h0000, 1, 0, -1);     // illegal
      do_reset();

      for (int n = 0; n < 120; n++) begin
         ins = rand_instr();
         run_instr(ins, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1);
         if (!is_legal(ins)) begin
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
